ppu_bg_fetch: RTL

PPU_BG_FETCH -- requirements
Module: ppu_bg_fetch

---
 rtl/ppu_bg_fetch.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ppu_bg_fetch.sv
// ---------------------------------------------------------------------------
// ppu_bg_fetch
//
// Purpose
//   NES-style background fetch pipeline. Each clock it takes one VGA sample
//   (col,row plus sync/visible flags), maps it onto the 256x240 NES
//   background (each NES pixel is 2x2 VGA pixels, 512x480 area), fetches
//   the name-table byte and then the two pattern-table planes from
//   external synchronous ROMs, and produces the 2-bit background colour
//   index. Every output for a sample appears together exactly 5 clocks
//   after the sample is presented.
//
//   Stage timing for a sample presented in cycle n:
//     n+1 : addr_ntable registered
//     n+2 : d_ntable valid from the ROM
//     n+3 : addr_ptable registered = {tile index, fine_y}
//     n+4 : d_ptable0/1 valid from the ROM
//     n+5 : px_idx, px_area, visible_o, hsync_o, vsync_o registered
//
//   Flow control: none. There is no valid/ready pair; the block accepts
//   one sample on every rising clock edge and can never stall.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-low reset
//   col, row     current VGA column / row (10 bits)
//   visible      VGA active-area flag
//   hsync_in     horizontal sync (negative polarity)
//   vsync_in     vertical sync (negative polarity)
//   scroll_x     requested horizontal scroll in NES pixels
//   addr_ntable  registered name-table ROM address
//   d_ntable     name-table ROM data (1-cycle ROM latency)
//   addr_ptable  registered pattern-table address (shared by both planes)
//   d_ptable0/1  pattern-table plane 0 / plane 1 data (1-cycle latency)
//   px_idx       background colour index {plane1 bit, plane0 bit}
//   px_area      pixel lies inside the 512x480 NES area
//   visible_o    delayed visible
//   hsync_o      delayed hsync_in
//   vsync_o      delayed vsync_in
// ---------------------------------------------------------------------------
module ppu_bg_fetch #(
  parameter int C_MEMW = 8,
  parameter int C_LAT  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        col,
  input  logic [9:0]        row,
  input  logic              visible,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [7:0]        scroll_x,
  output logic [9:0]        addr_ntable,
  input  logic [C_MEMW-1:0] d_ntable,
  output logic [10:0]       addr_ptable,
  input  logic [C_MEMW-1:0] d_ptable0,
  input  logic [C_MEMW-1:0] d_ptable1,
  output logic [1:0]        px_idx,
  output logic              px_area,
  output logic              visible_o,
  output logic              hsync_o,
  output logic              vsync_o
);

  // C_LAT only documents the latency; the pipeline depth is fixed at 5
  // because it is set by the two 1-cycle ROM round trips.
  localparam int LAT    = (C_LAT == 5) ? C_LAT : 5;
  // Sideband stage whose fine_y is paired with the returning name-table byte.
  localparam int STG_FY = 2;

  // Per-sample data that rides alongside the ROM accesses.
  typedef struct packed {
    logic [2:0] fine_x;
    logic [2:0] fine_y;
    logic       area;
    logic       vis;
    logic       hs;
    logic       vs;
  } side_t;

  // Syncs are negative polarity, so their idle (reset) value is 1.
  localparam side_t SIDE_RST = '{fine_x: 3'd0, fine_y: 3'd0, area: 1'b0,
                                 vis: 1'b0, hs: 1'b1, vs: 1'b1};

  logic [7:0]  scroll_q, scroll_d;
  logic [9:0]  addr_nt_q, addr_nt_d;
  logic [10:0] addr_pt_q, addr_pt_d;
  side_t       side_q [1:LAT-1];
  side_t       side_d;
  logic [1:0]  px_idx_q, px_idx_d;
  logic        px_area_q;
  logic        vis_q;
  logic        hs_q;
  logic        vs_q;

  logic        frame_start;
  logic [7:0]  scroll_eff;
  logic [7:0]  nes_x;
  logic [7:0]  nes_y;
  logic        in_area;
  logic [2:0]  bit_sel;

  always_comb begin
    frame_start = (col == 10'd0) && (row == 10'd0);
    // The frame's first sample already uses the scroll value being latched,
    // so the whole frame (including pixel 0,0) shares one scroll.
    scroll_eff  = frame_start ? scroll_x : scroll_q;
    scroll_d    = scroll_eff;

    // 8-bit add wraps horizontally: tile column 31 is followed by column 0.
    nes_x       = col[8:1] + scroll_eff;
    nes_y       = row[8:1];
    in_area     = (col < 10'd512) && (row < 10'd480) && visible;

    addr_nt_d   = {nes_y[7:3], nes_x[7:3]};

    side_d        = SIDE_RST;
    side_d.fine_x = nes_x[2:0];
    side_d.fine_y = nes_y[2:0];
    side_d.area   = in_area;
    side_d.vis    = visible;
    side_d.hs     = hsync_in;
    side_d.vs     = vsync_in;

    addr_pt_d   = {d_ntable[7:0], side_q[STG_FY].fine_y};

    // Pattern bytes hold the leftmost pixel in the MSB.
    bit_sel     = 3'd7 - side_q[LAT-1].fine_x;
    px_idx_d    = side_q[LAT-1].area ? {d_ptable1[bit_sel], d_ptable0[bit_sel]}
                                     : 2'b00;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scroll_q  <= 8'd0;
      addr_nt_q <= 10'd0;
      addr_pt_q <= 11'd0;
      for (int i = 1; i < LAT; i++) side_q[i] <= SIDE_RST;
      px_idx_q  <= 2'b00;
      px_area_q <= 1'b0;
      vis_q     <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
    end else begin
      scroll_q  <= scroll_d;
      addr_nt_q <= addr_nt_d;
      addr_pt_q <= addr_pt_d;
      side_q[1] <= side_d;
      for (int i = 2; i < LAT; i++) side_q[i] <= side_q[i-1];
      px_idx_q  <= px_idx_d;
      px_area_q <= side_q[LAT-1].area;
      vis_q     <= side_q[LAT-1].vis;
      hs_q      <= side_q[LAT-1].hs;
      vs_q      <= side_q[LAT-1].vs;
    end
  end

  assign addr_ntable = addr_nt_q;
  assign addr_ptable = addr_pt_q;
  assign px_idx      = px_idx_q;
  assign px_area     = px_area_q;
  assign visible_o   = vis_q;
  assign hsync_o     = hs_q;
  assign vsync_o     = vs_q;

endmodule
